// File: rtl/fpga_nav_controller_pkg.sv
// Shared types for the board-level navigation/host controller.
//   ctrl_state_t : controller FSM state, exported on ctrl_state
//   ctrl_err_t   : latched error code, exported on err_code
package fpga_nav_controller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ACK,
        RUN,
        DONE,
        ERROR
    } ctrl_state_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_BAD_N,
        ERR_NO_ACK
    } ctrl_err_t;

    localparam int N_OUT_W = 9;

endpackage

// File: rtl/fpga_nav_controller_btn_conditioner.sv
// Raw push-button conditioner: 2-FF synchroniser, debounce, rising-edge pulse.
//   clk, rst    : clock, synchronous active-high reset
//   raw         : asynchronous button input
//   level       : debounced level
//   rise_pulse  : one-cycle pulse per accepted 0->1 transition
// Press-to-pulse latency is 2 (sync) + DEB_CYCLES (stable) + 1 (pulse flop).
module btn_conditioner #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] DEB_RELOAD = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          prev_q;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Down-counter runs only while the synchronised level differs from the
    // accepted level; any return to the accepted level reloads it.
    always_comb begin
        level_d = level_q;
        cnt_d   = DEB_RELOAD;
        if (sync2_q != level_q) begin
            if (cnt_q == '0) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
        pulse_d = level_q & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= DEB_RELOAD;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            prev_q  <= level_q;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level      = level_q;
    assign rise_pulse = pulse_q;

endmodule

// File: rtl/fpga_nav_controller.sv
// Host controller between board buttons/switches and the systolic core.
//   clk, rst                 : clock, synchronous active-high reset
//   btn_left/right/start/step: raw buttons
//   sw_n, sw_wrap            : requested matrix size, cursor wrap enable
//   core_busy, core_done     : core handshake
//   n_out, addr_A/B/C        : latched matrix size and derived bases
//   addr_cursor              : memory inspection cursor
//   start_pulse, step_pulse  : one-cycle strobes to the core
//   ctrl_state, err_code     : run state and latched error
//
// state    | meaning
// IDLE     | after reset, waiting for a start press
// WAIT_ACK | start issued, waiting for core_busy (timeout -> ERROR)
// RUN      | core computing, start presses ignored
// DONE     | core finished, a start press begins a new run
// ERROR    | no ack from core, a start press retries
module fpga_nav_controller
    import fpga_nav_controller_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int N_MAX       = 4,
    parameter int AW          = 12,
    parameter int DEB_CYCLES  = 50000,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         btn_left,
    input  logic                         btn_right,
    input  logic                         btn_start,
    input  logic                         btn_step,
    input  logic [$clog2(N_MAX+1)-1:0]   sw_n,
    input  logic                         sw_wrap,
    input  logic                         core_busy,
    input  logic                         core_done,
    output logic [N_OUT_W-1:0]           n_out,
    output logic [AW-1:0]                addr_A,
    output logic [AW-1:0]                addr_B,
    output logic [AW-1:0]                addr_C,
    output logic [AW-1:0]                addr_cursor,
    output logic                         start_pulse,
    output logic                         step_pulse,
    output ctrl_state_t                  ctrl_state,
    output ctrl_err_t                    err_code
);

    localparam int SW = $clog2(N_MAX + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [SW-1:0] N_MAX_SW   = SW'(N_MAX);
    localparam logic [TW-1:0] TMR_RELOAD = TW'(ACK_TIMEOUT - 1);

    // Truncating n*n to AW bits below relies on the whole A/B/C region fitting.
    generate
        if (WIDTH < 1 || ACK_TIMEOUT < 1 || 3 * N_MAX * N_MAX >= 2 ** AW) begin : g_param_check
            $error("fpga_nav_controller: 3*N_MAX^2 must fit in AW bits");
        end
    endgenerate

    logic [3:0] btn_raw, btn_rise, btn_level_unused;
    assign btn_raw = {btn_step, btn_start, btn_right, btn_left};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
            .clk        (clk),
            .rst        (rst),
            .raw        (btn_raw[i]),
            .level      (btn_level_unused[i]),
            .rise_pulse (btn_rise[i])
        );
    end

    logic left_rise, right_rise, start_rise;
    assign left_rise  = btn_rise[0];
    assign right_rise = btn_rise[1];
    assign start_rise = btn_rise[2];

    ctrl_state_t          state_q, state_d;
    ctrl_err_t            err_q, err_d;
    logic [N_OUT_W-1:0]   n_out_q, n_out_d;
    logic                 start_q, start_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic [AW-1:0]        cursor_q, cursor_d;

    logic                 bad_n;
    logic [N_OUT_W-1:0]   n_eff;
    logic [2*N_OUT_W-1:0] n_ext;
    logic [AW-1:0]        n_sq, limit;
    logic                 start_ok;

    always_comb begin
        bad_n = (sw_n == '0) || (sw_n > N_MAX_SW);
        n_eff = bad_n ? N_OUT_W'(N_MAX) : N_OUT_W'(sw_n);
        n_ext = {{N_OUT_W{1'b0}}, n_out_q};
        n_sq  = AW'(n_ext * n_ext);
        limit = n_sq + (n_sq << 1) - AW'(1);
    end

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        n_out_d  = n_out_q;
        start_d  = 1'b0;
        tmr_d    = tmr_q;
        start_ok = start_rise && (state_q == IDLE || state_q == DONE || state_q == ERROR);

        case (state_q)
            WAIT_ACK: begin
                // A done before busy means the run was shorter than our sampling.
                if (core_done) begin
                    state_d = DONE;
                end else if (core_busy) begin
                    state_d = RUN;
                end else if (tmr_q == '0) begin
                    state_d = ERROR;
                    err_d   = ERR_NO_ACK;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            RUN: begin
                if (core_done) state_d = DONE;
            end
            default: ;
        endcase

        if (start_ok) begin
            state_d = WAIT_ACK;
            n_out_d = n_eff;
            err_d   = bad_n ? ERR_BAD_N : ERR_NONE;
            start_d = 1'b1;
            tmr_d   = TMR_RELOAD;
        end
    end

    // Clamp after a shrink takes priority over any movement in that cycle.
    always_comb begin
        cursor_d = cursor_q;
        if (cursor_q > limit) begin
            cursor_d = limit;
        end else if (right_rise && !left_rise) begin
            if (cursor_q == limit) cursor_d = sw_wrap ? '0 : cursor_q;
            else                   cursor_d = cursor_q + AW'(1);
        end else if (left_rise && !right_rise) begin
            if (cursor_q == '0) cursor_d = sw_wrap ? limit : cursor_q;
            else                cursor_d = cursor_q - AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            err_q    <= ERR_NONE;
            n_out_q  <= N_OUT_W'(N_MAX);
            start_q  <= 1'b0;
            tmr_q    <= TMR_RELOAD;
            cursor_q <= '0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            n_out_q  <= n_out_d;
            start_q  <= start_d;
            tmr_q    <= tmr_d;
            cursor_q <= cursor_d;
        end
    end

    assign n_out       = n_out_q;
    assign addr_A      = '0;
    assign addr_B      = n_sq;
    assign addr_C      = n_sq << 1;
    assign addr_cursor = cursor_q;
    assign start_pulse = start_q;
    assign step_pulse  = btn_rise[3];
    assign ctrl_state  = state_q;
    assign err_code    = err_q;

endmodule

// File: tb/tb_fpga_nav_controller.sv
module tb_fpga_nav_controller;
    import fpga_nav_controller_pkg::*;

    localparam int N_MAX = 4;
    localparam int AW    = 12;
    localparam int DEB   = 4;
    localparam int ACK   = 8;
    localparam int SWW   = $clog2(N_MAX + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_left = 0, btn_right = 0, btn_start = 0, btn_step = 0;
    logic [SWW-1:0] sw_n = '0;
    logic sw_wrap = 0, core_busy = 0, core_done = 0;
    logic [8:0] n_out;
    logic [AW-1:0] addr_A, addr_B, addr_C, addr_cursor;
    logic start_pulse, step_pulse;
    ctrl_state_t ctrl_state;
    ctrl_err_t err_code;

    fpga_nav_controller #(.WIDTH(16), .N_MAX(N_MAX), .AW(AW), .DEB_CYCLES(DEB), .ACK_TIMEOUT(ACK)) dut (
        .clk(clk), .rst(rst), .btn_left(btn_left), .btn_right(btn_right), .btn_start(btn_start),
        .btn_step(btn_step), .sw_n(sw_n), .sw_wrap(sw_wrap), .core_busy(core_busy), .core_done(core_done),
        .n_out(n_out), .addr_A(addr_A), .addr_B(addr_B), .addr_C(addr_C), .addr_cursor(addr_cursor),
        .start_pulse(start_pulse), .step_pulse(step_pulse), .ctrl_state(ctrl_state), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int n_start = 0, n_step = 0;
    int m_cursor = 0, m_n = N_MAX;
    ctrl_err_t m_err = ERR_NONE;

    always @(posedge clk) begin
        if (start_pulse) n_start++;
        if (step_pulse)  n_step++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    function automatic int lim(input int n);
        return 3 * n * n - 1;
    endfunction

    task automatic tick(input int k);
        repeat (k) begin @(posedge clk); @(negedge clk); end
    endtask

    // Reference cursor behaviour: one accepted press of each requested button.
    task automatic press(input bit l, input bit r);
        btn_left = l; btn_right = r; tick(10);
        btn_left = 0; btn_right = 0; tick(10);
        if (l && r) begin
        end else if (r) begin
            if (m_cursor == lim(m_n)) m_cursor = sw_wrap ? 0 : m_cursor;
            else m_cursor = m_cursor + 1;
        end else if (l) begin
            if (m_cursor == 0) m_cursor = sw_wrap ? lim(m_n) : 0;
            else m_cursor = m_cursor - 1;
        end
    endtask

    task automatic wait_start(output bit seen);
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick(1);
            if (start_pulse) seen = 1;
        end
    endtask

    // Holds btn_start until the strobe appears; caller releases it.
    task automatic start_run(input int sw, output bit seen);
        sw_n = SWW'(sw);
        btn_start = 1;
        wait_start(seen);
        if (seen) begin
            m_n   = (sw == 0 || sw > N_MAX) ? N_MAX : sw;
            m_err = (sw == 0 || sw > N_MAX) ? ERR_BAD_N : ERR_NONE;
            if (m_cursor > lim(m_n)) m_cursor = lim(m_n);
        end
    endtask

    task automatic release_start();
        btn_start = 0; tick(10);
    endtask

    task automatic finish_run();
        core_busy = 0; core_done = 1; tick(1); core_done = 0;
        checks++; if (ctrl_state !== DONE) begin errors++; $display("FAIL run_done state=%s exp=DONE", ctrl_state.name()); end
    endtask

    task automatic test_reset();
        rst = 1; tick(3); rst = 0; tick(1);
        m_cursor = 0; m_n = N_MAX;
        checks++; if (ctrl_state !== IDLE) begin errors++; $display("FAIL reset_state got=%s exp=IDLE", ctrl_state.name()); end
        checks++; if (addr_cursor !== 0) begin errors++; $display("FAIL reset_cursor got=%0d exp=0", addr_cursor); end
        checks++; if (n_out !== 9'd4) begin errors++; $display("FAIL reset_n got=%0d exp=4", n_out); end
        checks++; if (addr_A !== 0 || addr_B !== 16 || addr_C !== 32) begin errors++; $display("FAIL reset_bases got=%0d/%0d/%0d exp=0/16/32", addr_A, addr_B, addr_C); end
        checks++; if (err_code !== ERR_NONE) begin errors++; $display("FAIL reset_err got=%s exp=ERR_NONE", err_code.name()); end
        checks++; if (start_pulse !== 1'b0 || step_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulses got=%b%b exp=00", start_pulse, step_pulse); end
    endtask

    task automatic test_step_latency();
        int cyc = 0;
        int s0 = n_step;
        btn_step = 1;
        while (cyc < 20 && step_pulse !== 1'b1) begin tick(1); cyc++; end
        checks++; if (cyc !== 2 + DEB + 1) begin errors++; $display("FAIL step_latency got=%0d exp=%0d", cyc, 2 + DEB + 1); end
        tick(1);
        checks++; if (step_pulse !== 1'b0) begin errors++; $display("FAIL step_width got=%b exp=0", step_pulse); end
        btn_step = 0; tick(10);
        checks++; if (n_step - s0 !== 1) begin errors++; $display("FAIL step_count got=%0d exp=1", n_step - s0); end
    endtask

    task automatic test_bounce();
        btn_right = 1; tick(1); btn_right = 0; tick(1); btn_right = 1; tick(12);
        btn_right = 0; tick(12);
        m_cursor = 1;
        checks++; if (addr_cursor !== 1) begin errors++; $display("FAIL bounce_cursor got=%0d exp=1", addr_cursor); end
    endtask

    task automatic test_bounds();
        bit seen;
        start_run(2, seen);
        checks++; if (!seen) begin errors++; $display("FAIL bounds_start got=none exp=start_pulse"); end
        checks++; if (n_out !== 9'd2 || addr_B !== 4 || addr_C !== 8) begin errors++; $display("FAIL bounds_n got=%0d/%0d/%0d exp=2/4/8", n_out, addr_B, addr_C); end
        release_start();
        sw_wrap = 0;
        repeat (12) press(0, 1);
        checks++; if (addr_cursor !== 11) begin errors++; $display("FAIL bounds_sat got=%0d exp=11", addr_cursor); end
        sw_wrap = 1;
        press(0, 1);
        checks++; if (addr_cursor !== 0) begin errors++; $display("FAIL bounds_wrap_r got=%0d exp=0", addr_cursor); end
        press(1, 0);
        checks++; if (addr_cursor !== 11) begin errors++; $display("FAIL bounds_wrap_l got=%0d exp=11", addr_cursor); end
        for (int i = 0; i < 16; i++) begin
            int op;
            op = $urandom_range(0, 2);
            sw_wrap = 1'($urandom_range(0, 1));
            press(op != 1, op != 0);
            checks++; if (addr_cursor !== AW'(m_cursor)) begin errors++; $display("FAIL rand_cursor op=%0d wrap=%b got=%0d exp=%0d", op, sw_wrap, addr_cursor, m_cursor); end
        end
    endtask

    task automatic test_run();
        bit seen;
        int s0 = n_start;
        start_run(3, seen);
        checks++; if (!seen || start_pulse !== 1'b1) begin errors++; $display("FAIL run_start got=%b exp=1", start_pulse); end
        checks++; if (n_out !== 9'd3 || addr_B !== 9 || addr_C !== 18) begin errors++; $display("FAIL run_n got=%0d/%0d/%0d exp=3/9/18", n_out, addr_B, addr_C); end
        checks++; if (ctrl_state !== WAIT_ACK || err_code !== ERR_NONE) begin errors++; $display("FAIL run_wait got=%s/%s exp=WAIT_ACK/ERR_NONE", ctrl_state.name(), err_code.name()); end
        tick(1); core_busy = 1; tick(1);
        checks++; if (ctrl_state !== RUN) begin errors++; $display("FAIL run_busy got=%s exp=RUN", ctrl_state.name()); end
        release_start();
        checks++; if (n_start - s0 !== 1) begin errors++; $display("FAIL run_pulses got=%0d exp=1", n_start - s0); end
        finish_run();
    endtask

    task automatic test_timeout();
        bit seen;
        int cyc = 0;
        start_run(3, seen);
        while (cyc < 20 && ctrl_state !== ERROR) begin tick(1); cyc++; end
        checks++; if (!seen || cyc !== ACK) begin errors++; $display("FAIL timeout_cycles got=%0d exp=%0d", cyc, ACK); end
        checks++; if (err_code !== ERR_NO_ACK) begin errors++; $display("FAIL timeout_err got=%s exp=ERR_NO_ACK", err_code.name()); end
        release_start();
        start_run(3, seen);
        tick(1); core_busy = 1; tick(1);
        checks++; if (ctrl_state !== RUN || err_code !== ERR_NONE) begin errors++; $display("FAIL retry got=%s/%s exp=RUN/ERR_NONE", ctrl_state.name(), err_code.name()); end
        release_start();
        finish_run();
    endtask

    task automatic test_short_run();
        bit seen;
        start_run(4, seen);
        tick(2);
        finish_run();
        release_start();
    endtask

    task automatic test_bad_n();
        bit seen;
        int s0;
        start_run(7, seen);
        checks++; if (n_out !== 9'd4 || err_code !== ERR_BAD_N) begin errors++; $display("FAIL badn got=%0d/%s exp=4/ERR_BAD_N", n_out, err_code.name()); end
        core_busy = 1; tick(1);
        release_start();
        s0 = n_start;
        sw_n = 3'd2; btn_start = 1; tick(12); btn_start = 0; tick(10);
        checks++; if (n_start !== s0) begin errors++; $display("FAIL run_ignore_start got=%0d exp=0", n_start - s0); end
        checks++; if (n_out !== 9'd4 || addr_B !== 16 || addr_C !== 32 || ctrl_state !== RUN) begin errors++; $display("FAIL run_frozen got=%0d/%0d/%0d/%s exp=4/16/32/RUN", n_out, addr_B, addr_C, ctrl_state.name()); end
        finish_run();
        for (int i = 0; i < 5; i++) begin
            int sw;
            sw = $urandom_range(0, 7);
            start_run(sw, seen);
            checks++; if (!seen || n_out !== 9'(m_n) || addr_B !== AW'(m_n * m_n) || addr_C !== AW'(2 * m_n * m_n) || err_code !== m_err) begin
                errors++; $display("FAIL rand_n sw=%0d got=%0d/%0d/%0d/%s exp=%0d/%0d/%0d/%s", sw, n_out, addr_B, addr_C, err_code.name(), m_n, m_n * m_n, 2 * m_n * m_n, m_err.name());
            end
            tick(1);
            checks++; if (addr_cursor !== AW'(m_cursor)) begin errors++; $display("FAIL rand_n_cursor got=%0d exp=%0d", addr_cursor, m_cursor); end
            core_busy = 1; tick(1);
            release_start();
            finish_run();
        end
    endtask

    task automatic test_clamp();
        bit seen;
        int guard = 0;
        start_run(4, seen);
        core_busy = 1; tick(1);
        release_start();
        finish_run();
        sw_wrap = 0;
        while (m_cursor != 40 && guard < 60) begin
            press(m_cursor > 40, m_cursor < 40);
            guard++;
        end
        checks++; if (addr_cursor !== 40) begin errors++; $display("FAIL clamp_setup got=%0d exp=40", addr_cursor); end
        start_run(2, seen);
        tick(1);
        checks++; if (n_out !== 9'd2 || addr_cursor !== 11) begin errors++; $display("FAIL clamp got=%0d/%0d exp=2/11", n_out, addr_cursor); end
        core_busy = 1; tick(1);
        release_start();
        rst = 1; tick(1);
        checks++; if (ctrl_state !== IDLE || addr_cursor !== 0 || start_pulse !== 1'b0 || n_out !== 9'd4) begin
            errors++; $display("FAIL rst_in_run got=%s/%0d/%b/%0d exp=IDLE/0/0/4", ctrl_state.name(), addr_cursor, start_pulse, n_out);
        end
        rst = 0; core_busy = 0; tick(2);
        m_cursor = 0; m_n = N_MAX;
        btn_start = 1;
        wait_start(seen);
        rst = 1; btn_start = 0; tick(1);
        checks++; if (!seen || start_pulse !== 1'b0 || ctrl_state !== IDLE) begin errors++; $display("FAIL rst_drops_start got=%b/%s exp=0/IDLE", start_pulse, ctrl_state.name()); end
        rst = 0; tick(10);
    endtask

    initial begin
        test_reset();
        test_step_latency();
        test_bounce();
        test_bounds();
        test_run();
        test_timeout();
        test_short_run();
        test_bad_n();
        test_clamp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
